// File: rtl/dmem_lane_if.sv
// dmem_lane_if: request/response bundle for the byte-lane data memory.
//
// Handshake semantics (both channels): a transfer happens at a rising clock
// edge where valid and ready are both 1. The sender holds valid and its
// payload stable until that edge; ready may depend combinationally on the
// receiver's state. The master drives req_* and rsp_ready, and the slave
// drives req_ready and rsp_*.
interface dmem_lane_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane.sv
// dmem_lane: parameterised byte-lane data memory for the load/store stage.
// LANES byte banks are addressed with per-lane rotation, so any size at any
// byte address completes in one RAM cycle. A single pending register holds
// the response (latency 1, full throughput while rsp_ready=1).
// Optional feature macro: DMEM_ALIGN_CHECK_EN -- when defined, accesses whose
// address is not a multiple of the access size are rejected with rsp_err.
module dmem_lane #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  dmem_lane_if.slave bus,
  output logic       state_dbg
);
  localparam int LANES  = DATA_W / 8;
  localparam int SELW   = $clog2(LANES);
  localparam int WORD_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] TOTAL_BYTES = (ADDR_W+1)'(DEPTH * LANES);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  logic              load_q, load_d;

  logic              accept;
  logic              req_err;
  logic [SELW-1:0]   sel;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] word_nxt;
  logic [3:0]        nbytes;
  logic [ADDR_W:0]   last;
  logic [DATA_W-1:0] bank_rd;
  logic [DATA_W-1:0] rot;
  logic [DATA_W-1:0] ext;
  logic [SELW-1:0]   idx;
  logic [3:0]        nb_q;
  logic              sign;

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.req_ready = !bus.rsp_valid || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready;
  assign state_dbg     = state_q;

  // Request decode: lane select, base word, and access legality.
  always_comb begin
    sel      = bus.req_addr[SELW-1:0];
    word     = bus.req_addr[SELW +: WORD_W];
    word_nxt = word + WORD_W'(1);
    nbytes   = 4'd1 << bus.req_size;
    // Last byte touched, one bit wider so an access past the top of the
    // address space is still seen as out of range.
    last     = {1'b0, bus.req_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
    req_err  = (last >= TOTAL_BYTES) || (bus.req_size == 2'd3 && DATA_W == 32);
`ifdef DMEM_ALIGN_CHECK_EN
    if ((bus.req_addr[2:0] & 3'(nbytes - 4'd1)) != 3'd0) req_err = 1'b1;
`endif
  end

  // Byte banks. Bank i holds request byte k=(i-sel) mod LANES; banks below
  // sel belong to the next word because the access wrapped around the lanes.
  for (genvar i = 0; i < LANES; i++) begin : g_bank
    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_q;
    logic [SELW-1:0]   k;
    logic [WORD_W-1:0] baddr;
    logic              we;

    // Per-bank address, byte slot and write enable.
    always_comb begin
      k     = SELW'(i) - sel;
      baddr = (SELW'(i) < sel) ? word_nxt : word;
      we    = accept && bus.req_we && !req_err && (4'(k) < nbytes);
    end

    // Synchronous bank; read only on an accepted load so rd_q holds while
    // a response is stalled.
    always_ff @(posedge clk) begin
      if (we) mem[baddr] <= bus.req_wdata[k*8 +: 8];
      if (accept && !bus.req_we) rd_q <= mem[baddr];
    end

    assign bank_rd[i*8 +: 8] = rd_q;
  end

  // Response path: undo the lane rotation, then sign/zero extend.
  always_comb begin
    rot  = '0;
    ext  = '0;
    idx  = '0;
    sign = 1'b0;
    nb_q = 4'd1 << size_q;
    for (int k = 0; k < LANES; k++) begin
      idx = sel_q + SELW'(k);
      rot[k*8 +: 8] = bank_rd[idx*8 +: 8];
    end
    case (size_q)
      2'd0:    sign = rot[7];
      2'd1:    sign = rot[15];
      2'd2:    sign = rot[31];
      default: sign = rot[DATA_W-1];
    endcase
    for (int k = 0; k < LANES; k++) begin
      ext[k*8 +: 8] = (4'(k) < nb_q) ? rot[k*8 +: 8] : (uns_q ? 8'h00 : {8{sign}});
    end
  end

  assign bus.rsp_rdata = (bus.rsp_valid && load_q && !err_q) ? ext : '0;
  assign bus.rsp_err   = bus.rsp_valid && err_q;

  // Pending-response next state: capture on accept, drain on consume.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;
    load_d  = load_q;
    if (accept) begin
      state_d = RESP;
      sel_d   = sel;
      size_d  = bus.req_size;
      uns_d   = bus.req_unsigned;
      err_d   = req_err;
      load_d  = !bus.req_we;
    end else if (state_q == RESP && bus.rsp_ready) begin
      state_d = IDLE;
    end
  end

  // Pending-response register; reset discards any pending response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end
endmodule

// File: tb/tb_dmem_lane.sv
// tb_dmem_lane: directed, table-driven bench for dmem_lane (DATA_W=32,
// DEPTH=64), plus hand-written backpressure and mid-operation reset sequences.
module tb_dmem_lane;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  logic clk;
  logic reset;
  logic state_dbg;
  int   n_tests;
  int   n_fail;
  logic [DATA_W-1:0] exp_q[$];
  vec_t vecs[$];

  dmem_lane_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dmem_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input string name);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
  endtask

  // One transaction with rsp_ready=1: accepted at the next edge, response
  // checked half a cycle later (latency 1).
  task automatic txn(input vec_t v);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    drive(v.we, v.size, v.uns, v.addr, v.wdata);
    #1;
    check({v.name, " req_ready"}, 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({v.name, " rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    check({v.name, " rdata"}, 64'(bus.rsp_rdata), 64'(v.exp_rdata));
    check({v.name, " err"}, 64'(bus.rsp_err), 64'(v.exp_err));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bus.rsp_ready = 1'b1;
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    // Reset held with a request present.
    repeat (2) @(negedge clk);
    check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("reset rsp_err", 64'(bus.rsp_err), 64'd0);
    check("reset req_ready", 64'(bus.req_ready), 64'd1);
    check("reset state", 64'(state_dbg), 64'd0);
    bus.req_valid = 1'b0;
    reset = 1'b1;

    // Directed vectors: {we, size, uns, addr, wdata, exp_rdata, exp_err}
    vecs.push_back(mk(1, 2, 0, 32'h00, 32'h11223344, 32'h0, 0, "SW 00"));
    vecs.push_back(mk(1, 2, 0, 32'h0C, 32'h0, 32'h0, 0, "SW 0C zero"));
    vecs.push_back(mk(1, 2, 0, 32'h10, 32'h0, 32'h0, 0, "SW 10 zero"));
    vecs.push_back(mk(1, 2, 0, 32'h20, 32'h0, 32'h0, 0, "SW 20 zero"));
    vecs.push_back(mk(1, 2, 0, 32'h24, 32'h0, 32'h0, 0, "SW 24 zero"));
    vecs.push_back(mk(1, 2, 0, 32'h0E, 32'h55667788, 32'h0, ALIGN, "SW 0E mis"));
    vecs.push_back(mk(0, 2, 0, 32'h0E, 32'h0, ALIGN ? 32'h0 : 32'h55667788, ALIGN, "LW 0E"));
    vecs.push_back(mk(0, 2, 0, 32'h0C, 32'h0, ALIGN ? 32'h0 : 32'h77880000, 0, "LW 0C"));
    vecs.push_back(mk(0, 2, 0, 32'h10, 32'h0, ALIGN ? 32'h0 : 32'h00005566, 0, "LW 10 mis"));
    vecs.push_back(mk(1, 1, 0, 32'h21, 32'h1234BEEF, 32'h0, ALIGN, "SH 21"));
    vecs.push_back(mk(1, 1, 0, 32'h23, 32'h0000CAFE, 32'h0, ALIGN, "SH 23 cross"));
    vecs.push_back(mk(0, 2, 0, 32'h20, 32'h0, ALIGN ? 32'h0 : 32'hFEBEEF00, 0, "LW 20"));
    vecs.push_back(mk(0, 2, 0, 32'h24, 32'h0, ALIGN ? 32'h0 : 32'h000000CA, 0, "LW 24"));
    vecs.push_back(mk(0, 1, 0, 32'h23, 32'h0, ALIGN ? 32'h0 : 32'hFFFFCAFE, ALIGN, "LH 23"));
    vecs.push_back(mk(0, 1, 1, 32'h23, 32'h0, ALIGN ? 32'h0 : 32'h0000CAFE, ALIGN, "LHU 23"));
    vecs.push_back(mk(1, 2, 0, 32'h10, 32'hA1B2C3D4, 32'h0, 0, "SW 10"));
    vecs.push_back(mk(0, 0, 0, 32'h10, 32'h0, 32'hFFFFFFD4, 0, "LB 10"));
    vecs.push_back(mk(0, 0, 1, 32'h10, 32'h0, 32'h000000D4, 0, "LBU 10"));
    vecs.push_back(mk(0, 1, 0, 32'h12, 32'h0, 32'hFFFFA1B2, 0, "LH 12"));
    vecs.push_back(mk(0, 1, 1, 32'h12, 32'h0, 32'h0000A1B2, 0, "LHU 12"));
    vecs.push_back(mk(0, 2, 0, 32'h10, 32'h0, 32'hA1B2C3D4, 0, "LW 10"));
    vecs.push_back(mk(0, 0, 0, 32'h11, 32'h0, 32'hFFFFFFC3, 0, "LB 11"));
    vecs.push_back(mk(0, 0, 1, 32'h13, 32'h0, 32'h000000A1, 0, "LBU 13"));
    vecs.push_back(mk(0, 2, 0, 32'hFE, 32'h0, 32'h0, 1, "LW FE range"));
    vecs.push_back(mk(1, 2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 1, "SW 100 range"));
    vecs.push_back(mk(0, 2, 0, 32'h00, 32'h0, 32'h11223344, 0, "LW 00 after SW 100"));
    vecs.push_back(mk(1, 0, 0, 32'hFF, 32'h00000080, 32'h0, 0, "SB FF"));
    vecs.push_back(mk(0, 0, 0, 32'hFF, 32'h0, 32'hFFFFFF80, 0, "LB FF"));
    vecs.push_back(mk(0, 0, 1, 32'hFF, 32'h0, 32'h00000080, 0, "LBU FF"));
    vecs.push_back(mk(0, 3, 0, 32'h00, 32'h0, 32'h0, 1, "LD size3"));
    vecs.push_back(mk(1, 3, 0, 32'h00, 32'hFFFFFFFF, 32'h0, 1, "SD size3"));
    vecs.push_back(mk(0, 2, 0, 32'h00, 32'h0, 32'h11223344, 0, "LW 00 after SD"));

    foreach (vecs[i]) txn(vecs[i]);

    // Backpressure: two back-to-back loads, response stalled for 3 cycles.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    exp_q.push_back(32'hA1B2C3D4);
    @(negedge clk);
    drive(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
    exp_q.push_back(ALIGN ? 32'h0 : 32'h77880000);
    for (int c = 0; c < 3; c++) begin
      check("bp stall rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp stall req_ready", 64'(bus.req_ready), 64'd0);
      check("bp stall rdata", 64'(bus.rsp_rdata), 64'(exp_q[0]));
      check("bp stall err", 64'(bus.rsp_err), 64'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp release req_ready", 64'(bus.req_ready), 64'd1);
    check("bp first rdata", 64'(bus.rsp_rdata), 64'(exp_q.pop_front()));
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("bp second rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("bp second rdata", 64'(bus.rsp_rdata), 64'(exp_q.pop_front()));
    @(negedge clk);
    check("bp drained rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("bp drained state", 64'(state_dbg), 64'd0);

    // Reset mid-operation drops the pending response without a clock edge.
    bus.rsp_ready = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst-mid pending", 64'(bus.rsp_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rst-mid rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst-mid rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst-mid req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    txn(mk(0, 2, 0, 32'h10, 32'h0, 32'hA1B2C3D4, 0, "LW 10 after reset"));

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_lane.md
# dmem_lane

Parameterised byte-lane data memory for the load/store stage. It replaces the fixed 32-bit, 64-word data memory with configurable data width and depth. Loads and stores of any size, at any byte address, complete in a single RAM cycle through per-lane address rotation. It adds a valid/ready request/response handshake with backpressure, sign/zero extension of loads, and error reporting for out-of-range or unsupported accesses.

## Interface
Parameters:
- DATA_W, 32: data width in bits; legal values are 32 and 64. LANES = DATA_W/8, SELW = log2(LANES).
- DEPTH, 64: words per memory; power of two. Total bytes = DEPTH*LANES.
- ADDR_W, 32: byte address width.

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (DATA_W=64 only).
- req_unsigned  in  1  load zero-extends when set, sign-extends otherwise.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, least-significant bytes used.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores, errors, and whenever rsp_valid=0.
- rsp_err  out  1  access rejected; qualified by rsp_valid.

## Operation
- Storage is LANES byte banks of DEPTH entries each. Each bank is synchronous-read and synchronous-write, with a read enable.
- Lane mapping: sel = req_addr[SELW-1:0], word = req_addr[ADDR_W-1:SELW].
  - Bank i is addressed at word+1 when i < sel, otherwise at word.
  - Request byte k maps to bank (sel+k) mod LANES.
- Store: bank (sel+k) mod LANES writes req_wdata byte k, for k < 2^req_size.
- Load: result byte k is bank (sel+k) mod LANES q, for k < 2^req_size. The remaining bytes are the sign bit of the top byte, or 0 when the load is unsigned.
- Errors:
  - last = req_addr + 2^req_size - 1, computed at ADDR_W+1 bits. last >= DEPTH*LANES is an error.
  - req_size=3 with DATA_W=32 is an error.
  - On error, no bank is written, rsp_err=1 and rsp_rdata=0.
- Banks are read-enabled only on an accepted load, so q holds while a response is stalled.
- State: single pending register (IDLE/RESP). It holds sel, size, unsigned, err and a load flag.
  - IDLE -> RESP on accept.
  - RESP -> IDLE on rsp_ready without a new accept.
  - RESP -> RESP on consume plus a new accept.
- req_ready = !rsp_valid | rsp_ready.
- Reset:
  - rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1.
  - A pending response is discarded.
  - Bank contents are not reset.

## Timing
- Latency is 1: a request accepted at edge E gives a response valid after E, for both loads and stores.
- Throughput is 1 request per cycle while rsp_ready=1. Misaligned and word-crossing accesses take no extra cycles.
- A store at E followed by a load of the same bytes at E+1 returns the new data.
- Backpressure:
  - While rsp_valid & !rsp_ready: rsp_rdata and rsp_err stay stable, req_ready=0, and no request is accepted.
  - Responses return in request order.
- An asynchronous reset assertion drops rsp_valid immediately, without waiting for a clock edge.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: any access with req_addr not a multiple of 2^req_size gives rsp_err=1, with no write and rsp_rdata=0.
- DMEM_ALIGN_CHECK_EN undefined: misaligned accesses are fully supported through lane rotation, with single-cycle latency.

## Test plan
- Reset: hold reset=0 with req_valid=1 -> rsp_valid=0, rsp_rdata=0, req_ready=1. Release -> first request is accepted.
- Extension (DATA_W=32, DEPTH=64): store word 0xA1B2C3D4 at 0x10, then load:
  - LB 0x10 -> 0xFFFFFFD4
  - LBU 0x10 -> 0x000000D4
  - LH 0x12 -> 0xFFFFA1B2
  - LHU 0x12 -> 0x0000A1B2
  - LW 0x10 -> 0xA1B2C3D4
- Misaligned, macro undefined: store word 0x55667788 at 0x0E over zeroed memory -> LW 0x0E = 0x55667788, LW 0x0C = 0x77880000, LW 0x10 = 0x00005566, each with 1-cycle latency. With the macro defined: rsp_err=1 and memory is unchanged.
- Backpressure: LW 0x10 then LW 0x0C back-to-back with rsp_ready=0 for 3 cycles -> the first response is held stable and req_ready=0. Releasing rsp_ready gives 0xA1B2C3D4, then the second response the next cycle.
- Range: LW 0xFE -> rsp_err=1, rsp_rdata=0; SW 0x100 -> rsp_err=1 with no write; LB 0xFF -> no error; size=3 with DATA_W=32 -> rsp_err=1.
- Reset mid-operation: accept LW 0x10 with rsp_ready=0, then pull reset low -> rsp_valid=0 immediately. After release, LW 0x10 still returns 0xA1B2C3D4.
